switch_input_conditioner: RTL and testbench



---
 rtl/io_pkg.sv | 21 ++
 rtl/switch_input_conditioner_if.sv | 10 +
 rtl/debounce_filter.sv | 62 ++++++
 rtl/switch_input_conditioner.sv | 111 +++++++++++
 tb/tb_switch_input_conditioner.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared IO definitions for the switch input conditioner: register map,
// status bit positions and switch vector width.
package io_pkg;

  localparam int SWITCH_WIDTH = 24;

  // IO register select values decoded from io_addr.
  typedef enum logic [1:0] {
    IO_ADDR_SWITCH = 2'd0,
    IO_ADDR_STATUS = 2'd1,
    IO_ADDR_CASE   = 2'd2,
    IO_ADDR_RSVD   = 2'd3
  } io_addr_e;

  // Bit positions inside the STATUS register.
  localparam int STAT_LEVEL = 0;
  localparam int STAT_BUSY  = 1;
  localparam int STAT_RISE  = 2;
  localparam int STAT_FALL  = 3;

endpackage

// File: rtl/switch_input_conditioner_if.sv
// CPU-facing IO read port of the switch input conditioner.
// The master drives the strobe and address; the slave returns registered data.
interface switch_input_conditioner_if;
  logic        io_read_en;
  logic [1:0]  io_addr;
  logic [31:0] io_read_data;

  modport master (output io_read_en, output io_addr, input io_read_data);
  modport slave  (input io_read_en, input io_addr, output io_read_data);
endinterface

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a whole-vector debounce filter.
// A new value is accepted only after it has been seen unchanged for
// DEBOUNCE_CYCLES consecutive cycles; any change restarts the window.
// watch_next_o exposes the next-cycle value of one chosen bit so the
// caller can detect edges on the same clock edge the vector updates.
module debounce_filter #(
  parameter int WIDTH           = 24,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WATCH_BIT       = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             busy_o,
  output logic             watch_next_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q, cand_q, stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Window counter and accept decision for the candidate vector.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != cand_q) begin
      cnt_d = '0;
    end else if (cand_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = cand_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser, candidate, counter and accepted-value registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      cand_q   <= s2_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o     = stable_q;
  assign busy_o       = (cand_q != stable_q);
  assign watch_next_o = stable_d[WATCH_BIT];

endmodule

// File: rtl/switch_input_conditioner.sv
// Switch input conditioner: debounced board switches, enter-key edge
// flags (read-to-clear) and a three-register IO read port.
// Optional build macro ENTER_FALL_DETECT_EN adds the enter release flag;
// without it the fall flag reads as constant 0.
module switch_input_conditioner
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ENTER_BIT       = 20,
  parameter int CASE_MSB        = 23
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SWITCH_WIDTH-1:0] switch_raw,
  switch_input_conditioner_if.slave bus,
  output logic [SWITCH_WIDTH-1:0] switch_stable,
  output logic                    enter_pulse
);

  logic        cnt_busy;
  logic        enter_next;
  logic        enter_rise;
  logic        status_rd;
  logic        enter_pulse_q;
  logic        rise_pending_q;
  logic        fall_pending;
  logic [31:0] rd_data_d, rd_data_q;

  debounce_filter #(
    .WIDTH           (SWITCH_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WATCH_BIT       (ENTER_BIT)
  ) u_debounce (
    .clock        (clock),
    .reset        (reset),
    .raw_i        (switch_raw),
    .stable_o     (switch_stable),
    .busy_o       (cnt_busy),
    .watch_next_o (enter_next)
  );

  // Edges are taken on the edge where the debounced enter bit changes.
  assign enter_rise = enter_next & ~switch_stable[ENTER_BIT];
  assign status_rd  = bus.io_read_en && (bus.io_addr == IO_ADDR_STATUS);

  // Enter pulse and rise flag; a new edge wins over a same-edge clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      enter_pulse_q  <= 1'b0;
      rise_pending_q <= 1'b0;
    end else begin
      enter_pulse_q <= enter_rise;
      if (enter_rise) begin
        rise_pending_q <= 1'b1;
      end else if (status_rd) begin
        rise_pending_q <= 1'b0;
      end
    end
  end

`ifdef ENTER_FALL_DETECT_EN
  logic enter_fall;
  logic fall_pending_q;

  assign enter_fall = ~enter_next & switch_stable[ENTER_BIT];

  // Release flag for the release-to-accept protocol; set wins over clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      fall_pending_q <= 1'b0;
    end else if (enter_fall) begin
      fall_pending_q <= 1'b1;
    end else if (status_rd) begin
      fall_pending_q <= 1'b0;
    end
  end

  assign fall_pending = fall_pending_q;
`else
  assign fall_pending = 1'b0;
`endif

  // Read mux; the status word carries flag values from before any clear.
  always_comb begin
    rd_data_d = '0;
    case (bus.io_addr)
      IO_ADDR_SWITCH: rd_data_d = 32'(switch_stable);
      IO_ADDR_STATUS: begin
        rd_data_d[STAT_LEVEL] = switch_stable[ENTER_BIT];
        rd_data_d[STAT_BUSY]  = cnt_busy;
        rd_data_d[STAT_RISE]  = rise_pending_q;
        rd_data_d[STAT_FALL]  = fall_pending;
      end
      IO_ADDR_CASE:   rd_data_d = 32'(switch_stable[CASE_MSB -: 3]);
      default:        rd_data_d = '0;
    endcase
  end

  // Read data register, loaded only on a strobe and held otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (bus.io_read_en) begin
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.io_read_data = rd_data_q;
  assign enter_pulse      = enter_pulse_q;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Self-checking bench for switch_input_conditioner with DEBOUNCE_CYCLES = 4.
// Register reads push their expected word to a scoreboard queue when the
// strobe is driven and pop it when the registered data appears.
module tb_switch_input_conditioner;
  import io_pkg::*;

`ifdef ENTER_FALL_DETECT_EN
  localparam logic [31:0] FALL_BIT = 32'h8;
`else
  localparam logic [31:0] FALL_BIT = 32'h0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] switch_raw;
  logic [23:0] switch_stable;
  logic        enter_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  switch_input_conditioner_if bus ();

  switch_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .ENTER_BIT       (20),
    .CASE_MSB        (23)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .switch_raw    (switch_raw),
    .bus           (bus),
    .switch_stable (switch_stable),
    .enter_pulse   (enter_pulse)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (enter_pulse) pulse_cnt++;
    end
  endtask

  task automatic do_read(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus.io_read_en = 1'b1;
    bus.io_addr    = addr;
    tick(1);
    bus.io_read_en = 1'b0;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      check_eq(tag_q.pop_front(), bus.io_read_data, exp_q.pop_front());
    end
  endtask

  initial begin
    reset          = 1'b1;
    switch_raw     = '0;
    bus.io_read_en = 1'b0;
    bus.io_addr    = 2'd0;
    tick(3);
    check_eq("rst_stable", 32'(switch_stable), 32'h0);
    check_eq("rst_rdata", bus.io_read_data, 32'h0);
    check_eq("rst_pulse", 32'(enter_pulse), 32'h0);
    reset = 1'b0;

    // Plain switch change: accepted on the 7th edge.
    switch_raw = 24'h000001;
    tick(6);
    check_eq("sw_before_window", 32'(switch_stable), 32'h0);
    tick(1);
    check_eq("sw_after_window", 32'(switch_stable), 32'h1);
    do_read(IO_ADDR_SWITCH, 32'h00000001, "rd_switch");

    // Enter bounce, then a clean hold.
    pulse_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      switch_raw = 24'h100001;
      tick(2);
      switch_raw = 24'h000001;
      tick(2);
    end
    switch_raw = 24'h100001;
    tick(6);
    check_eq("bounce_no_pulse", 32'(pulse_cnt), 32'd0);
    check_eq("bounce_stable_held", 32'(switch_stable), 32'h000001);
    tick(1);
    check_eq("enter_stable", 32'(switch_stable), 32'h100001);
    check_eq("enter_pulse_hi", 32'(enter_pulse), 32'h1);
    tick(1);
    check_eq("enter_pulse_lo", 32'(enter_pulse), 32'h0);
    check_eq("enter_pulse_once", 32'(pulse_cnt), 32'd1);
    do_read(IO_ADDR_STATUS, 32'h5, "status_rise");
    do_read(IO_ADDR_STATUS, 32'h1, "status_cleared");

    // Case field; enter released in the same change.
    switch_raw = 24'hA00000;
    tick(3);
    do_read(IO_ADDR_STATUS, 32'h3, "status_busy");
    tick(3);
    check_eq("case_stable", 32'(switch_stable), 32'hA00000);
    do_read(IO_ADDR_STATUS, FALL_BIT, "status_fall");
    do_read(IO_ADDR_RSVD, 32'h0, "rd_reserved");
    do_read(IO_ADDR_CASE, 32'h5, "rd_case");
    tick(2);
    check_eq("rdata_hold", bus.io_read_data, 32'h5);

    // Enter rise on the same edge as a status read.
    pulse_cnt = 0;
    switch_raw = 24'hB00000;
    tick(6);
    do_read(IO_ADDR_STATUS, 32'h2, "status_same_edge");
    check_eq("same_edge_pulse", 32'(enter_pulse), 32'h1);
    do_read(IO_ADDR_STATUS, 32'h5, "status_rise_kept");
    check_eq("same_edge_pulse_once", 32'(pulse_cnt), 32'd1);

    // Enter release from a stable high.
    switch_raw = 24'hA00000;
    tick(7);
    check_eq("release_stable", 32'(switch_stable), 32'hA00000);
    do_read(IO_ADDR_STATUS, FALL_BIT, "status_release");

    // Reset in the middle of a pending change.
    switch_raw = 24'h0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    pulse_cnt = 0;
    switch_raw = 24'h100003;
    tick(2);
    reset = 1'b1;
    tick(2);
    check_eq("midrst_stable", 32'(switch_stable), 32'h0);
    check_eq("midrst_rdata", bus.io_read_data, 32'h0);
    reset = 1'b0;
    do_read(IO_ADDR_STATUS, 32'h0, "midrst_no_flags");
    tick(5);
    check_eq("midrst_before", 32'(switch_stable), 32'h0);
    tick(1);
    check_eq("midrst_after", 32'(switch_stable), 32'h100003);
    check_eq("midrst_pulse_once", 32'(pulse_cnt), 32'd1);
    do_read(IO_ADDR_STATUS, 32'h5, "midrst_status");

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
